noc_rx_deframer: RTL and testbench
==================================

# noc_rx_deframer

Device-side receive stage directly downstream of the NOC-to-device port: consumes the `noc_to_dev_ctl`/`noc_to_dev_data` byte stream, parses headers, packs payload bytes into 32-bit little-endian words and buffers them in a FIFO. Words leave on a valid/ready interface with packet delimiters to the device core. The NOC side has no backpressure, so the block admits a packet only when the FIFO can hold all of it.

## Interface
- `FIFO_DEPTH`, 8, payload FIFO entries; power of two, ≥4.
- `DEV_ID`, 4'h0, this device's NOC address (used only with filtering enabled).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low.
- `noc_to_dev_ctl` in 1: 1 = header byte, 0 = payload byte.
- `noc_to_dev_data` in 8: byte lane, valid every cycle.
- `out_valid` out 1: word available.
- `out_ready` in 1: consumer accepts the word when `out_valid & out_ready`.
- `out_data` out 32: payload word; byte 0 in [7:0].
- `out_be` out 4: byte enables; contiguous from bit 0.
- `out_sop` out 1: first word of packet.
- `out_eop` out 1: last word of packet.
- `out_err` out 1: packet truncated; qualifies the EOP word.
- `rx_pkt_cnt` out 16: packets admitted; wraps.
- `drop_cnt` out 8: packets dropped; saturates at 255.
- `err_cnt` out 8: truncated packets plus stray payload bytes; saturates at 255.

## Operation
- Header byte: [7:4] destination id, [3:0] payload length N (0–15).
- Input register: `ctl`/`data` are sampled every edge into an input stage; all parsing acts on the registered copy.
- States: IDLE, PAYLOAD, DROP.

IDLE:
- `ctl=1`, N=0: discard the packet, no output, `rx_pkt_cnt`+1.
- `ctl=1`, N>0: admit when FIFO free entries ≥ ceil(N/4). On admit, go to PAYLOAD with remaining=N, `rx_pkt_cnt`+1. Otherwise go to DROP, `drop_cnt`+1.
- `ctl=0`: discard the byte, `err_cnt`+1.

PAYLOAD:
- Each `ctl=0` byte goes into the next byte lane.
- A word is pushed when 4 bytes are collected or remaining reaches 0.
- The first pushed word has `sop=1`; the word holding the last byte has `eop=1`. Then return to IDLE.

PAYLOAD, truncation (`ctl=1` before remaining=0):
- Push the partial word: `be` covers the bytes received (4'b0000 if none), `eop=1`, `err=1`, and `sop=1` if no word of this packet was pushed yet.
- `err_cnt`+1.
- The new header is processed in the same cycle, exactly as in IDLE.
- The space reserved at admission guarantees room for this push.

DROP:
- Discard `ctl=0` bytes until the count reaches N.
- On reaching N, return to IDLE.
- A `ctl=1` byte is handled as a header.

Output side:
- FIFO with non-fall-through read: `out_*` are driven from the head entry whenever the FIFO is non-empty.
- A push and a pop may occur in the same cycle, including when the FIFO is full; occupancy is unchanged.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_be`=0, `out_sop`=0, `out_eop`=0, `out_err`=0, all counters=0, state=IDLE, FIFO empty, input register holds `ctl=0`.
- Reset asserted mid-packet: FIFO contents and any partial word are discarded immediately.
- First reception after reset deassertion: the first sampled byte is treated normally.
- Latency: a byte on the bus before edge k is registered at k. If it completes a word, the push happens at k+1 and `out_valid` is high after k+1.
- Admission check uses FIFO occupancy at the header's processing edge; a pop on that same edge is not credited.
- Output contents hold stable while `out_valid & ~out_ready`.
- Counter saturation: at 255, `drop_cnt`/`err_cnt` hold; `rx_pkt_cnt` wraps 65535→0.

## Configuration
- `NOC_RX_DEST_FILTER_EN` defined: a header with destination ≠ `DEV_ID` enters DROP and does not increment `drop_cnt`.
- `NOC_RX_DEST_FILTER_EN` undefined: the destination field is ignored, `DEV_ID` is unused, and all packets are subject to the space check only.

## Test plan
- Header 8'h06, bytes 11..16, `out_ready`=1 → word 0x14131211 with be=F and sop=1; then word 0x00001615 with be=3 and eop=1. `rx_pkt_cnt`=1.
- Header 8'h05, 3 bytes AA BB CC, then header 8'h02 → word 0x00CCBBAA with be=7, sop=1, eop=1, err=1. `err_cnt`=1. The next packet parses normally.
- `out_ready`=0, FIFO_DEPTH=8, two N=15 packets (4 words each) then a third N=1 packet → first two buffered (8 words). Third dropped; `drop_cnt`=1.
- Stray payload bytes 01 02 in IDLE, then header 8'h00 → no output, `err_cnt`=2, `rx_pkt_cnt`=1.
- With `NOC_RX_DEST_FILTER_EN`, `DEV_ID`=4'h3: header 8'h52 plus 2 bytes → no output, counters unchanged. Header 8'h32 plus 2 bytes → one word with be=3.
- Reset pulse mid-payload → all outputs and counters return to 0 asynchronously. The next header is processed normally.

Source files
------------

// File: rtl/noc_rx_deframer.sv
// noc_rx_deframer: parses NOC header/payload bytes, packs payload into 32-bit LE words and queues them.
// Define NOC_RX_DEST_FILTER_EN to drop packets whose destination differs from DEV_ID.
module noc_rx_deframer #(
   parameter int         FIFO_DEPTH = 8,
   parameter logic [3:0] DEV_ID     = 4'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        noc_to_dev_ctl,
   input  logic [7:0]  noc_to_dev_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [3:0]  out_be,
   output logic        out_sop,
   output logic        out_eop,
   output logic        out_err,
   output logic [15:0] rx_pkt_cnt,
   output logic [7:0]  drop_cnt,
   output logic [7:0]  err_cnt
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, PAYLOAD, DROP} state_t;
   state_t        state_q, state_d;
   logic          in_vld_q, in_ctl_q;
   logic [7:0]    in_data_q;
   logic [3:0]    rem_q, rem_d;
   logic [1:0]    lane_q, lane_d;
   logic [31:0]   word_q, word_d, word_nx;
   logic          first_q, first_d;
   logic [38:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [AW+1:0] occ;
   logic [15:0]   rx_q, rx_d;
   logic [7:0]    drop_q, drop_d, err_q, err_d;
   logic [2:0]    nb, need;
   logic [38:0]   push_entry;
   logic          push, push_last, push_err, hdr, pop, filt, admit;
   logic          rx_inc, drop_inc, err_inc;
`ifdef NOC_RX_DEST_FILTER_EN
   assign filt = in_data_q[7:4] != DEV_ID;
`else
   logic unused_dev_id;
   assign unused_dev_id = ^DEV_ID;
   assign filt = 1'b0;
`endif
   assign pop   = out_valid & out_ready;
   assign need  = {1'b0, in_data_q[3:2]} + {2'b00, |in_data_q[1:0]};
   // A truncation push in this cycle already occupies a slot the new header cannot claim.
   assign occ   = {1'b0, cnt_q} + (AW+2)'(push) + (AW+2)'(need);
   assign admit = occ <= (AW+2)'(FIFO_DEPTH);
   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      lane_d    = lane_q;
      word_d    = word_q;
      first_d   = first_q;
      push      = 1'b0;
      push_last = 1'b0;
      push_err  = 1'b0;
      hdr       = 1'b0;
      rx_inc    = 1'b0;
      drop_inc  = 1'b0;
      err_inc   = 1'b0;
      nb        = {1'b0, lane_q};
      word_nx   = word_q | ({24'd0, in_data_q} << {lane_q, 3'b000});
      if (in_vld_q && in_ctl_q) begin
         hdr       = 1'b1;
         push      = state_q == PAYLOAD;
         push_last = push;
         push_err  = push;
         err_inc   = push;
      end else if (in_vld_q) begin
         if (state_q == IDLE)
            err_inc = 1'b1;
         else if (state_q == DROP) begin
            rem_d   = rem_q - 4'd1;
            state_d = (rem_q == 4'd1) ? IDLE : DROP;
         end else begin
            rem_d     = rem_q - 4'd1;
            lane_d    = lane_q + 2'd1;
            word_d    = word_nx;
            nb        = {1'b0, lane_q} + 3'd1;
            push      = lane_q == 2'd3 || rem_q == 4'd1;
            push_last = rem_q == 4'd1;
            if (push) begin
               lane_d  = 2'd0;
               word_d  = 32'd0;
               first_d = 1'b0;
            end
            state_d = push_last ? IDLE : PAYLOAD;
         end
      end
      if (hdr) begin
         state_d = IDLE;
         lane_d  = 2'd0;
         word_d  = 32'd0;
         first_d = 1'b1;
         rem_d   = in_data_q[3:0];
         if (filt)
            state_d = (in_data_q[3:0] != 4'd0) ? DROP : IDLE;
         else if (in_data_q[3:0] == 4'd0)
            rx_inc = 1'b1;
         else if (admit) begin
            state_d = PAYLOAD;
            rx_inc  = 1'b1;
         end else begin
            state_d  = DROP;
            drop_inc = 1'b1;
         end
      end
      push_entry = {push_err, push_last, first_q, ~(4'hF << nb), hdr ? word_q : word_nx};
      wr_d   = wr_q + AW'(push);
      rd_d   = rd_q + AW'(pop);
      cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      rx_d   = rx_q + 16'(rx_inc);
      drop_d = drop_q + 8'(drop_inc && drop_q != 8'hFF);
      err_d  = err_q + 8'(err_inc && err_q != 8'hFF);
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_vld_q  <= 1'b0;
         in_ctl_q  <= 1'b0;
         in_data_q <= 8'd0;
         state_q   <= IDLE;
         rem_q     <= 4'd0;
         lane_q    <= 2'd0;
         word_q    <= 32'd0;
         first_q   <= 1'b1;
         wr_q      <= '0;
         rd_q      <= '0;
         cnt_q     <= '0;
         rx_q      <= 16'd0;
         drop_q    <= 8'd0;
         err_q     <= 8'd0;
      end else begin
         in_vld_q  <= 1'b1;
         in_ctl_q  <= noc_to_dev_ctl;
         in_data_q <= noc_to_dev_data;
         state_q   <= state_d;
         rem_q     <= rem_d;
         lane_q    <= lane_d;
         word_q    <= word_d;
         first_q   <= first_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         cnt_q     <= cnt_d;
         rx_q      <= rx_d;
         drop_q    <= drop_d;
         err_q     <= err_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= push_entry;
   end
   assign out_valid = cnt_q != '0;
   assign {out_err, out_eop, out_sop, out_be, out_data} = out_valid ? mem_q[rd_q] : 39'd0;
   assign rx_pkt_cnt = rx_q;
   assign drop_cnt   = drop_q;
   assign err_cnt    = err_q;
endmodule

// File: tb/tb_noc_rx_deframer.sv
// tb_noc_rx_deframer: randomized and directed stimulus checked every cycle against a packet-level model.
module tb_noc_rx_deframer;
   localparam int         DEPTH = 8;
   localparam logic [3:0] DEV   = 4'h3;
   localparam logic [7:0] HD    = {DEV, 4'h0};
   logic        clk = 1'b0, reset = 1'b0, ctl = 1'b0, out_ready = 1'b0;
   logic [7:0]  data = 8'd0;
   logic        out_valid, out_sop, out_eop, out_err;
   logic [31:0] out_data;
   logic [3:0]  out_be;
   logic [15:0] rx_pkt_cnt;
   logic [7:0]  drop_cnt, err_cnt;
   int checks = 0, errors = 0;
   bit rr = 1'b0;
   int rdy_pct = 100;
   logic [38:0] acc [$];
   logic [38:0] mq [$];
   logic [7:0]  pb [$];
   int mode, plen, nw, ndrop;
   logic [15:0] m_rx;
   logic [7:0]  m_drop, m_err, m_dat;
   logic        m_vld, m_ctl;
   bit          pop_now;

   noc_rx_deframer #(.FIFO_DEPTH(DEPTH), .DEV_ID(DEV)) dut (
      .clk(clk), .reset(reset), .noc_to_dev_ctl(ctl), .noc_to_dev_data(data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_be(out_be),
      .out_sop(out_sop), .out_eop(out_eop), .out_err(out_err),
      .rx_pkt_cnt(rx_pkt_cnt), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [38:0] acc_at(int i);
      return (i < acc.size()) ? acc[i] : '1;
   endfunction

   // Model: packets are byte lists; a word is emitted per 4 bytes, at the last byte, or on truncation.
   task automatic mpush(logic eop, logic err);
      logic [31:0] d;
      int k;
      d = '0;
      k = pb.size() - nw * 4;
      for (int i = 0; i < k; i++) d[8*i +: 8] = pb[nw*4+i];
      mq.push_back({err, eop, nw == 0, 4'((1 << k) - 1), d});
      nw++;
   endtask

   task automatic mhdr(logic [7:0] h);
      int n;
      n = int'(h[3:0]);
      mode = 0;
`ifdef NOC_RX_DEST_FILTER_EN
      if (h[7:4] != DEV) begin
         if (n > 0) begin mode = 2; plen = n; ndrop = 0; end
         return;
      end
`endif
      if (n == 0) m_rx++;
      else if (mq.size() + (n + 3) / 4 <= DEPTH) begin
         mode = 1; plen = n; pb.delete(); nw = 0; m_rx++;
      end else begin
         mode = 2; plen = n; ndrop = 0;
         if (m_drop != 8'hFF) m_drop++;
      end
   endtask

   task automatic mstep(logic c, logic [7:0] d);
      if (c) begin
         if (mode == 1) begin
            mpush(1'b1, 1'b1);
            if (m_err != 8'hFF) m_err++;
         end
         mhdr(d);
      end else if (mode == 0) begin
         if (m_err != 8'hFF) m_err++;
      end else if (mode == 1) begin
         pb.push_back(d);
         if (pb.size() == plen) begin mpush(1'b1, 1'b0); mode = 0; end
         else if (pb.size() % 4 == 0) mpush(1'b0, 1'b0);
      end else begin
         ndrop++;
         if (ndrop == plen) mode = 0;
      end
   endtask

   initial forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
         mq.delete(); pb.delete();
         mode = 0; m_rx = 0; m_drop = 0; m_err = 0; m_vld = 0; m_ctl = 0; m_dat = 0;
      end else begin
         pop_now = out_ready && mq.size() > 0;
         if (m_vld) mstep(m_ctl, m_dat);
         if (pop_now) mq.delete(0);
         m_ctl = ctl; m_dat = data; m_vld = 1'b1;
      end
   end

   initial forever begin
      @(negedge clk);
      if (!reset) begin
         chk("rst_outs", {out_valid, out_err, out_eop, out_sop, out_be, out_data}, 64'd0);
         chk("rst_cnts", {rx_pkt_cnt, drop_cnt, err_cnt}, 64'd0);
      end else begin
         chk("valid", out_valid, mq.size() != 0);
         if (mq.size() != 0) chk("head", {out_err, out_eop, out_sop, out_be, out_data}, mq[0]);
         chk("counters", {rx_pkt_cnt, drop_cnt, err_cnt}, {m_rx, m_drop, m_err});
         if (out_valid && out_ready) acc.push_back({out_err, out_eop, out_sop, out_be, out_data});
      end
   end

   task automatic send(logic c, logic [7:0] d);
      ctl = c;
      data = d;
      if (rr) out_ready = $urandom_range(0, 99) < rdy_pct;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(int n);
      repeat (n) send(1'b1, HD);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      acc.delete();
   endtask

   initial begin
      int n, k;
      logic [7:0] h;
      do_reset();
      chk("reset_cnts", {rx_pkt_cnt, drop_cnt, err_cnt}, 64'd0);
      chk("reset_valid", out_valid, 1'b0);
      // Basic 6-byte packet
      out_ready = 1'b1;
      send(1'b1, HD | 8'h06);
      for (int i = 0; i < 6; i++) send(1'b0, 8'(8'h11 + i));
      send(1'b1, HD);
      chk("t1_rx", rx_pkt_cnt, 16'd1);
      idle(6);
      chk("t1_n", acc.size(), 2);
      chk("t1_w0", acc_at(0), {1'b0, 1'b0, 1'b1, 4'hF, 32'h14131211});
      chk("t1_w1", acc_at(1), {1'b0, 1'b1, 1'b0, 4'h3, 32'h00001615});
      // Truncation followed by a clean packet
      do_reset();
      out_ready = 1'b1;
      send(1'b1, HD | 8'h05);
      send(1'b0, 8'hAA); send(1'b0, 8'hBB); send(1'b0, 8'hCC);
      send(1'b1, HD | 8'h02);
      send(1'b0, 8'hDD); send(1'b0, 8'hEE);
      send(1'b1, HD);
      chk("t2_err", err_cnt, 8'd1);
      chk("t2_rx", rx_pkt_cnt, 16'd2);
      idle(6);
      chk("t2_w0", acc_at(0), {1'b1, 1'b1, 1'b1, 4'h7, 32'h00CCBBAA});
      chk("t2_w1", acc_at(1), {1'b0, 1'b1, 1'b1, 4'h3, 32'h0000EEDD});
      // Full FIFO: third packet dropped, then drop_cnt saturates
      do_reset();
      out_ready = 1'b0;
      for (int p = 0; p < 2; p++) begin
         send(1'b1, HD | 8'h0F);
         for (int i = 0; i < 15; i++) send(1'b0, 8'(i + 1));
      end
      send(1'b1, HD | 8'h01); send(1'b0, 8'h55);
      send(1'b1, HD);
      chk("t3_drop", drop_cnt, 8'd1);
      chk("t3_rx", rx_pkt_cnt, 16'd2);
      chk("t3_valid", out_valid, 1'b1);
      repeat (260) send(1'b1, HD | 8'h01);
      send(1'b1, HD);
      chk("t3_drop_sat", drop_cnt, 8'd255);
      out_ready = 1'b1;
      idle(12);
      chk("t3_n", acc.size(), 8);
      chk("t3_w0", acc_at(0), {1'b0, 1'b0, 1'b1, 4'hF, 32'h04030201});
      chk("t3_w3", acc_at(3), {1'b0, 1'b1, 1'b0, 4'h7, 32'h000F0E0D});
      chk("t3_w4", acc_at(4), {1'b0, 1'b0, 1'b1, 4'hF, 32'h04030201});
      // Stray bytes in IDLE, then err_cnt saturation
      do_reset();
      send(1'b0, 8'h01); send(1'b0, 8'h02);
      send(1'b1, HD);
      send(1'b1, HD);
      chk("t4_err", err_cnt, 8'd2);
      chk("t4_rx", rx_pkt_cnt, 16'd1);
      chk("t4_valid", out_valid, 1'b0);
      repeat (300) send(1'b0, 8'($urandom));
      send(1'b1, HD);
      chk("t4_err_sat", err_cnt, 8'd255);
      // Destination field: filtered or ignored depending on build
      do_reset();
      out_ready = 1'b1;
      send(1'b1, 8'h52); send(1'b0, 8'hB1); send(1'b0, 8'hB2);
      send(1'b1, HD);
`ifdef NOC_RX_DEST_FILTER_EN
      chk("t5_cnts", {rx_pkt_cnt, drop_cnt, err_cnt}, 64'd0);
      chk("t5_valid", out_valid, 1'b0);
`else
      chk("t5_rx", rx_pkt_cnt, 16'd1);
`endif
      send(1'b1, HD | 8'h02); send(1'b0, 8'hA1); send(1'b0, 8'hA2);
      idle(5);
`ifdef NOC_RX_DEST_FILTER_EN
      chk("t5_n", acc.size(), 1);
      chk("t5_w", acc_at(0), {1'b0, 1'b1, 1'b1, 4'h3, 32'h0000A2A1});
`else
      chk("t5_n", acc.size(), 2);
      chk("t5_w0", acc_at(0), {1'b0, 1'b1, 1'b1, 4'h3, 32'h0000B2B1});
      chk("t5_w1", acc_at(1), {1'b0, 1'b1, 1'b1, 4'h3, 32'h0000A2A1});
`endif
      // Asynchronous reset mid-payload
      do_reset();
      out_ready = 1'b0;
      send(1'b1, HD | 8'h08);
      for (int i = 0; i < 6; i++) send(1'b0, 8'(i + 1));
      chk("t6_rx", rx_pkt_cnt, 16'd1);
      chk("t6_valid", out_valid, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk("t6_async_valid", out_valid, 1'b0);
      chk("t6_async_cnts", {rx_pkt_cnt, drop_cnt, err_cnt}, 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      acc.delete();
      send(1'b1, HD | 8'h01); send(1'b0, 8'h77);
      send(1'b1, HD);
      chk("t6_rx2", rx_pkt_cnt, 16'd1);
      out_ready = 1'b1;
      idle(3);
      chk("t6_w", acc_at(0), {1'b0, 1'b1, 1'b1, 4'h1, 32'h00000077});
      // Randomized traffic with varying backpressure
      do_reset();
      rr = 1'b1;
      for (int p = 0; p < 500; p++) begin
         if (p % 40 == 0) rdy_pct = $urandom_range(0, 100);
         if ($urandom_range(0, 9) == 0) send(1'b0, 8'($urandom));
         else begin
            h = 8'($urandom);
            n = int'(h[3:0]);
            k = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n) : n;
            send(1'b1, h);
            for (int i = 0; i < k; i++) send(1'b0, 8'($urandom));
         end
      end
      rr = 1'b0;
      out_ready = 1'b1;
      idle(20);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
